// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the burst-oriented FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int max_cnt);
      return $clog2(max_cnt + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last,
// wrapping modulo NUM_REQ, so the previous winner has lowest priority.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]             i_req,
   input  logic [idx_width(NUM_REQ)-1:0]  i_last,
   output logic [idx_width(NUM_REQ)-1:0]  o_winner,
   output logic                           o_any_req
);

   localparam int IDX_W = idx_width(NUM_REQ);

   logic w_found;
   int   w_idx;

   // NOTE: every variable driven here gets a default first, so no path
   // through the loop can leave a value held and infer a latch.
   always_comb begin
      o_winner = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = (int'(i_last) + k) % NUM_REQ;
         if (!w_found && i_req[w_idx]) begin
            o_winner = IDX_W'(w_idx);
            w_found  = 1'b1;
         end
      end
   end

   assign o_any_req = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ
// producers; a grant is held until the owner's burst ends.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              gnt,
   output logic                            fifo_wren,
   output logic [DATA_WIDTH-1:0]           fifo_data,
   input  logic                            fifo_full,
   output logic [idx_width(NUM_REQ)-1:0]   owner,
   output logic                            busy
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = cnt_width(MAX_BURST);

   arb_state_t        r_state;
   logic [IDX_W-1:0]  r_owner;
   logic [IDX_W-1:0]  r_last;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic              r_busy;

   logic [IDX_W-1:0]  w_winner;
   logic              w_any_req;
   logic              w_owner_req;
   logic              w_owner_last;
   logic              w_beat;
   logic              w_burst_end;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .i_req     (req),
      .i_last    (r_last),
      .o_winner  (w_winner),
      .o_any_req (w_any_req)
   );

   assign w_owner_req  = req[r_owner];
   assign w_owner_last = req_last[r_owner];

   // Gating with rst_n keeps the reset cycle write-free even mid-burst.
   assign w_beat      = rst_n && (r_state == ARB_BURST) && w_owner_req && !fifo_full;
   assign w_burst_end = w_owner_last || (r_beat_cnt == CNT_W'(MAX_BURST - 1));

   always_comb begin
      gnt       = '0;
      fifo_wren = 1'b0;
      fifo_data = '0;
      if (w_beat) begin
         gnt[r_owner] = 1'b1;
         fifo_wren    = 1'b1;
         fifo_data    = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ARB_IDLE;
         r_owner    <= '0;
         r_last     <= IDX_W'(NUM_REQ - 1);
         r_beat_cnt <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_any_req) begin
                  r_owner    <= w_winner;
                  r_last     <= w_winner;
                  r_beat_cnt <= '0;
                  r_state    <= ARB_BURST;
                  r_busy     <= 1'b1;
               end
            end
            ARB_BURST: begin
               if (!w_owner_req) begin
                  r_state <= ARB_IDLE;
                  r_busy  <= 1'b0;
               end else if (!fifo_full) begin
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                  if (w_burst_end) begin
                     r_state <= ARB_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ARB_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign owner = r_owner;
   assign busy  = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, corner sequences and
// randomized traffic against a rule-level reference model.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_last;
   logic [NR-1:0]    gnt;
   logic             fifo_wren;
   logic [DW-1:0]    fifo_data;
   logic             fifo_full;
   logic [1:0]       owner;
   logic             busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .req_last  (req_last),
      .gnt       (gnt),
      .fifo_wren (fifo_wren),
      .fifo_data (fifo_data),
      .fifo_full (fifo_full),
      .owner     (owner),
      .busy      (busy)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model: who owns the port, who won last, beats accepted so far.
   bit m_busy;
   int m_owner;
   int m_last;
   int m_cnt;
   int wr_q[$];

   typedef struct {
      logic [NR-1:0]    rq;
      logic [NR*DW-1:0] dat;
      logic [NR-1:0]    lst;
      logic             full;
      logic [NR-1:0]    e_gnt;
      logic             e_wren;
      logic [DW-1:0]    e_data;
      logic [1:0]       e_owner;
      logic             e_busy;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int rr_winner(input logic [NR-1:0] rq, input int lst);
      for (int k = 1; k <= NR; k++) begin
         if (rq[(lst + k) % NR]) return (lst + k) % NR;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic drive(input logic rst, input logic [NR-1:0] rq, input logic [NR*DW-1:0] dat,
                        input logic [NR-1:0] lst, input logic full);
      @(negedge clk);
      rst_n     = rst;
      req       = rq;
      req_data  = dat;
      req_last  = lst;
      fifo_full = full;
      #1;
   endtask

   task automatic do_reset(input bit chk_state);
      drive(1'b0, '0, '0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b0);
      if (chk_state) begin
         check("rst_gnt",   gnt, 0);
         check("rst_wren",  fifo_wren, 0);
         check("rst_data",  fifo_data, 0);
         check("rst_owner", owner, 0);
         check("rst_busy",  busy, 0);
      end
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = NR - 1;
      m_cnt   = 0;
      wr_q.delete();
   endtask

   // One model-checked clock cycle.
   task automatic cycle(input logic rst, input logic [NR-1:0] rq, input logic [NR*DW-1:0] dat,
                        input logic [NR-1:0] lst, input logic full);
      logic          beat;
      logic [NR-1:0] eg;
      int            w;
      drive(rst, rq, dat, lst, full);
      beat = rst && m_busy && rq[m_owner] && !full;
      eg   = beat ? (NR'(1) << m_owner) : '0;
      check("gnt",  gnt, eg);
      check("wren", fifo_wren, beat);
      if (beat) check("data", fifo_data, dat[m_owner*DW +: DW]);
      check("owner", owner, m_owner);
      check("busy",  busy, m_busy);
      if (fifo_wren) wr_q.push_back(onehot_idx(gnt));
      if (!rst) begin
         m_busy  = 1'b0;
         m_owner = 0;
         m_last  = NR - 1;
         m_cnt   = 0;
      end else if (!m_busy) begin
         w = rr_winner(rq, m_last);
         if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            m_cnt   = 0;
            m_busy  = 1'b1;
         end
      end else if (!rq[m_owner]) begin
         m_busy = 1'b0;
      end else if (!full) begin
         m_cnt++;
         if (lst[m_owner] || m_cnt == MB) m_busy = 1'b0;
      end
   endtask

   initial begin
      logic [NR-1:0]    r_rq;
      logic [NR-1:0]    r_lst;
      logic [NR*DW-1:0] dat4;

      rst_n = 1'b0; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;

      // -- Vector table: short burst, stall + last, abandon --
      tbl[0]  = '{4'b0001, 32'h000000A1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[1]  = '{4'b0001, 32'h000000A1, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'hA1, 2'd0, 1'b1};
      tbl[2]  = '{4'b0001, 32'h000000A2, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'hA2, 2'd0, 1'b1};
      tbl[3]  = '{4'b0001, 32'h000000A3, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA3, 2'd0, 1'b1};
      tbl[4]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[5]  = '{4'b0010, 32'h0000B100, 4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[6]  = '{4'b0010, 32'h0000B100, 4'b0010, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1};
      tbl[7]  = '{4'b0010, 32'h0000B100, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b1};
      tbl[8]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
      tbl[9]  = '{4'b1000, 32'hD0000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
      tbl[10] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1};
      tbl[11] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};

      do_reset(1'b1);
      for (int v = 0; v < 12; v++) begin
         drive(1'b1, tbl[v].rq, tbl[v].dat, tbl[v].lst, tbl[v].full);
         check($sformatf("tbl%0d_gnt", v),   gnt,       tbl[v].e_gnt);
         check($sformatf("tbl%0d_wren", v),  fifo_wren, tbl[v].e_wren);
         if (tbl[v].e_wren) check($sformatf("tbl%0d_data", v), fifo_data, tbl[v].e_data);
         check($sformatf("tbl%0d_owner", v), owner,     tbl[v].e_owner);
         check($sformatf("tbl%0d_busy", v),  busy,      tbl[v].e_busy);
      end

      // -- All requesting, no last: 8-beat bursts in order 0,1,2,3 then 0 --
      do_reset(1'b0);
      dat4 = 32'h33221100;
      for (int c = 0; c < 36; c++) cycle(1'b1, 4'b1111, dat4, 4'b0000, 1'b0);
      check("rr_writes_36cyc", wr_q.size(), 32);
      if (wr_q.size() >= 32)
         for (int k = 0; k < 32; k += 4) check($sformatf("rr_owner_w%0d", k), wr_q[k], k / 8);
      cycle(1'b1, 4'b1111, dat4, 4'b0000, 1'b0);
      check("rr_idle_gap", fifo_wren, 0);
      cycle(1'b1, 4'b1111, dat4, 4'b0000, 1'b0);
      check("rr_wrap_gnt", gnt, 4'b0001);

      // -- FIFO full for 3 cycles mid-burst of requester 2 --
      do_reset(1'b0);
      dat4 = 32'h00C00000;
      for (int c = 0; c < 4; c++) cycle(1'b1, 4'b0100, dat4, 4'b0000, 1'b0);
      for (int c = 0; c < 3; c++) begin
         cycle(1'b1, 4'b0100, dat4, 4'b0000, 1'b1);
         check("stall_wren", fifo_wren, 0);
         check("stall_gnt", gnt, 0);
      end
      for (int c = 0; c < 5; c++) cycle(1'b1, 4'b0100, dat4, 4'b0000, 1'b0);
      check("stall_total", wr_q.size(), MB);
      cycle(1'b1, 4'b0000, dat4, 4'b0000, 1'b0);
      check("stall_done_busy", busy, 0);

      // -- Owner 1 abandons after 2 beats while req[3] pending --
      do_reset(1'b0);
      dat4 = 32'h4400_2200;
      for (int c = 0; c < 3; c++) cycle(1'b1, 4'b1010, dat4, 4'b0000, 1'b0);
      cycle(1'b1, 4'b1000, dat4, 4'b0000, 1'b0);
      check("abandon_no_write", fifo_wren, 0);
      cycle(1'b1, 4'b1000, dat4, 4'b0000, 1'b0);
      check("abandon_writes", wr_q.size(), 2);
      cycle(1'b1, 4'b1000, dat4, 4'b0000, 1'b0);
      check("abandon_next_owner", owner, 3);
      check("abandon_next_gnt", gnt, 4'b1000);

      // -- Reset during beat 4 of requester 2 --
      do_reset(1'b0);
      dat4 = 32'h44332211;
      for (int c = 0; c < 4; c++) cycle(1'b1, 4'b0100, dat4, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0100, dat4, 4'b0000, 1'b0);
      check("midrst_no_write", fifo_wren, 0);
      cycle(1'b1, 4'b0110, dat4, 4'b0000, 1'b0);
      check("midrst_idle", busy, 0);
      cycle(1'b1, 4'b0110, dat4, 4'b0000, 1'b0);
      check("midrst_owner", owner, 1);
      check("midrst_gnt", gnt, 4'b0010);

      // -- req_last on the MAX_BURST-th beat --
      do_reset(1'b0);
      dat4 = 32'h000055AA;
      for (int c = 0; c < MB; c++) cycle(1'b1, 4'b0011, dat4, 4'b0000, 1'b0);
      cycle(1'b1, 4'b0011, dat4, 4'b0001, 1'b0);
      check("lastmax_writes", wr_q.size(), MB);
      cycle(1'b1, 4'b0011, dat4, 4'b0000, 1'b0);
      check("lastmax_idle", fifo_wren, 0);
      cycle(1'b1, 4'b0011, dat4, 4'b0000, 1'b0);
      check("lastmax_next_gnt", gnt, 4'b0010);

      // -- Randomized traffic against the model --
      do_reset(1'b0);
      for (int c = 0; c < 3000; c++) begin
         r_rq = NR'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++) r_lst[i] = ($urandom_range(0, 7) == 0);
         cycle(($urandom_range(0, 199) != 0), r_rq, $urandom, r_lst, ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one FIFO write port among NUM_REQ requesters in bursts. It sits directly in front of the FIFO write side (wren/i_data/full) and grants one requester at a time. A grant holds until that requester's burst ends, giving each producer contiguous FIFO entries and fair access.

## Interface
- NUM_REQ, 4: number of requesters; must be ≥ 2.
- DATA_WIDTH, 8: word width; matches the FIFO.
- MAX_BURST, 8: maximum accepted beats per grant; must be ≥ 1.

- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  NUM_REQ  per-requester valid; word offered this cycle.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened words; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final word of requester i's burst.
- gnt  output  NUM_REQ  one-hot or zero; gnt[i]=1 means requester i's word is written this cycle.
- fifo_wren  output  1  FIFO write enable.
- fifo_data  output  DATA_WIDTH  FIFO write data.
- fifo_full  input  1  FIFO full flag.
- owner  output  $clog2(NUM_REQ)  index of the current or most recent burst owner.
- busy  output  1  high while in BURST.

## Operation
- States: ARB_IDLE, ARB_BURST.
- ARB_IDLE:
  - No grants are issued.
  - If any req bit is set, pick the first set bit searching upward from last+1, wrapping modulo NUM_REQ.
  - Register the winner into owner and last, clear beat_cnt, and go to ARB_BURST.
- ARB_BURST:
  - A beat is accepted when req[owner] && !fifo_full.
  - On a beat: gnt[owner] = fifo_wren = 1, fifo_data = owner's slice, beat_cnt += 1.
  - fifo_full stalls the burst. No gnt or wren is issued, beat_cnt holds, and the grant is kept.
  - Return to ARB_IDLE after any cycle where one of these holds:
    - an accepted beat has req_last[owner]=1;
    - an accepted beat brings beat_cnt to MAX_BURST;
    - req[owner]=0 (owner abandons; no beat that cycle).
- Both end conditions (last and MAX_BURST) in the same beat cause a single exit with no extra beat.
- beat_cnt width is $clog2(MAX_BURST+1) and never wraps.
- Non-owner req, req_data and req_last are ignored during a burst.
- fifo_wren is never asserted while fifo_full=1. The FIFO is never overrun.
- Reset values: state ARB_IDLE, last = NUM_REQ-1 (so requester 0 wins first), owner 0, beat_cnt 0, busy 0, gnt 0, fifo_wren 0, fifo_data 0.
- Reset asserted mid-burst aborts the burst on that edge. No write occurs in the reset cycle.

## Timing
- gnt, fifo_wren and fifo_data are combinational from state/owner, req, fifo_full and req_data. There is no register in the data path.
- state, owner, last, beat_cnt and busy are registered.
- Arbitration latency: req rises in cycle N (state IDLE), and the first beat can be granted in cycle N+1.
- Each burst is followed by one ARB_IDLE cycle. Peak throughput per burst is MAX_BURST beats per MAX_BURST+1 cycles.
- A requester holds req_data and req_last stable until it sees gnt.

## Structure
- Package fifo_arb_pkg holds:
  - typedef enum logic [0:0] arb_state_t {ARB_IDLE, ARB_BURST};
  - localparam function for clog2-based widths.
- Sub-module rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: req vector and last index.
  - Outputs: winner index and any_req.
  - Parameterised by NUM_REQ.
- Top contains the FSM, counters and the output mux.

## Test plan
- Reset then req=4'b0001, data 0xA1..0xA3, req_last on 3rd beat -> owner=0; gnt[0] in cycles 2,3,4; FIFO receives A1,A2,A3; busy drops after cycle 4.
- req=4'b1111 held, no req_last, MAX_BURST=8 -> bursts of exactly 8 beats in order 0,1,2,3,0; one idle cycle between bursts; 32 writes per 36 cycles.
- fifo_full pulsed high 3 cycles mid-burst of requester 2 -> fifo_wren=0 and gnt=0 for those 3 cycles; beat_cnt frozen; burst resumes and still totals MAX_BURST beats.
- Owner 1 drops req after 2 beats while req[3]=1 -> burst ends with 2 writes; next owner is 3, not 0 or 2.
- rst_n low during beat 4 of a burst by requester 2 -> no write that cycle; after release, req=4'b0110 grants requester 1 first.
- req_last coincident with the MAX_BURST-th beat -> exactly MAX_BURST writes, one exit, next requester granted after a single idle cycle.
